// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha1_pkg
// Description : Shared constants, FSM encoding and the ROTL1 helper used by
//               the SHA-1 message-schedule stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sha1_pkg;

    localparam logic [7:0] SHA1_ROUNDS  = 8'h50;
    localparam int         SHA1_WORD_W  = 32;
    localparam int         SHA1_BLOCK_W = 512;

    // Schedule FSM: IDLE waits for a block, RUN streams W0..W79
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sha1_state_e;

    // One-bit left rotate of a schedule word
    function automatic logic [SHA1_WORD_W-1:0] rotl1(input logic [SHA1_WORD_W-1:0] x);
        return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_w_expand.sv
`default_nettype none
// ============================================================================
// Module      : sha1_w_expand
// Description : Combinational schedule expansion:
//               o_w = ROTL1(i_w13 ^ i_w8 ^ i_w2 ^ i_w0)
// Revision    : 1.0 - initial release
// ============================================================================
module sha1_w_expand
    import sha1_pkg::*;
(
    input  logic [SHA1_WORD_W-1:0] i_w13,
    input  logic [SHA1_WORD_W-1:0] i_w8,
    input  logic [SHA1_WORD_W-1:0] i_w2,
    input  logic [SHA1_WORD_W-1:0] i_w0,
    output logic [SHA1_WORD_W-1:0] o_w
);

    assign o_w = rotl1(i_w13 ^ i_w8 ^ i_w2 ^ i_w0);

endmodule
`default_nettype wire

// File: rtl/sha1_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha1_msg_sched
// Description : SHA-1 message schedule. Captures a 512-bit block and emits
//               W0..W79 one per cycle in lockstep with the controller's round
//               index t, flagging any index misalignment in sync_err.
// Revision    : 1.0 - initial release
// ============================================================================
module sha1_msg_sched
    import sha1_pkg::*;
#(
    parameter logic [7:0] ROUNDS = SHA1_ROUNDS
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic [SHA1_BLOCK_W-1:0] block,
    input  logic [7:0]              t,
    output logic [SHA1_WORD_W-1:0]  w_t,
    output logic                    w_valid,
    output logic                    busy,
    output logic                    sync_err
);

    sha1_state_e            r_state;
    sha1_state_e            w_state_nxt;
    logic [SHA1_WORD_W-1:0] r_win [16];
    logic [6:0]             r_idx;
    logic                   r_sync_err;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_sync_set;
    logic [SHA1_WORD_W-1:0] w_new;

    // Next window word, derived from the four taps of the current window
    sha1_w_expand u_expand (
        .i_w13 (r_win[13]),
        .i_w8  (r_win[8]),
        .i_w2  (r_win[2]),
        .i_w0  (r_win[0]),
        .o_w   (w_new)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus load/shift/sync-error strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sync_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // valid is deliberately ignored here: blocks only enter from IDLE
                if (t < ROUNDS) begin
                    w_shift = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                if (t > ROUNDS) begin
                    w_sync_set = 1'b1;
                end
                if (t[7] || (t[6:0] != r_idx)) begin
                    w_sync_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // 16-word sliding window; win[0] always holds the current W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= block[SHA1_BLOCK_W-1-SHA1_WORD_W*i -: SHA1_WORD_W];
            end
        end else if (w_shift) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_new;
        end
    end

    // Internal round index, saturating at ROUNDS so it cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (w_shift && (r_idx < ROUNDS[6:0])) begin
            r_idx <= r_idx + 7'd1;
        end
    end

    // Sticky sync error, cleared only by an accepted block or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err <= 1'b0;
        end else if (w_load) begin
            r_sync_err <= 1'b0;
        end else if (w_sync_set) begin
            r_sync_err <= 1'b1;
        end
    end

    assign w_t      = r_win[0];
    assign busy     = (r_state == ST_RUN);
    assign w_valid  = (r_state == ST_RUN) && (t < ROUNDS);
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha1_msg_sched
// Description : Self-checking bench for sha1_msg_sched. The bench plays the
//               round controller, driving t, and compares every W against a
//               straightforward array model of the SHA-1 schedule recurrence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha1_msg_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [511:0] block = '0;
    logic [7:0]   t = '0;
    logic [31:0]  w_t;
    logic         w_valid;
    logic         busy;
    logic         sync_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_w    [80];
    logic [31:0] obs      [80];
    logic [31:0] obs_abc  [80];
    logic [31:0] obs_ones [80];

    typedef struct {
        bit          use_ones;
        int          k;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    sha1_msg_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .block    (block),
        .t        (t),
        .w_t      (w_t),
        .w_valid  (w_valid),
        .busy     (busy),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic logic [511:0] randblk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r;
    endfunction

    // Reference schedule: W[i] = M[i] for i<16, else ROTL1 of the four taps
    task automatic model(input logic [511:0] blk);
        logic [31:0] x;
        for (int i = 0; i < 80; i++) begin
            if (i < 16) begin
                exp_w[i] = blk[511-32*i -: 32];
            end else begin
                x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
                exp_w[i] = (x << 1) | (x >> 31);
            end
        end
    endtask

    // Starts just after a falling edge with the DUT idle; leaves the bench just
    // after the falling edge of the first idle cycle (or of the reset cycle).
    task automatic run_block(input logic [511:0] blk, input int skip, input int rst_at,
                             input bit mid_pulse);
        int nvalid;
        bit exp_sync;
        nvalid   = 0;
        exp_sync = 1'b0;
        model(blk);
        valid = 1'b1;
        block = blk;
        @(posedge clk); #1;
        valid = 1'b0;
        block = randblk();
        for (int k = 0; k <= 80; k++) begin
            t     = (k == skip) ? 8'(k + 1) : 8'(k);
            valid = (mid_pulse && k == 20) ? 1'b1 : 1'b0;
            if (valid) block = randblk();
            if (k == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_mid w_t", w_t, 32'h0);
                chk("rst_mid busy", {31'h0, busy}, 32'h0);
                chk("rst_mid w_valid", {31'h0, w_valid}, 32'h0);
                chk("rst_mid sync_err", {31'h0, sync_err}, 32'h0);
                rst_n = 1'b1;
                t     = 8'h0;
                return;
            end
            @(negedge clk);
            if (k < 80) begin
                chk($sformatf("w_t[%0d]", k), w_t, exp_w[k]);
                obs[k] = w_t;
            end
            chk($sformatf("w_valid[%0d]", k), {31'h0, w_valid}, (k < 80) ? 32'h1 : 32'h0);
            chk($sformatf("busy[%0d]", k), {31'h0, busy}, 32'h1);
            chk($sformatf("sync_err[%0d]", k), {31'h0, sync_err}, {31'h0, exp_sync});
            if (w_valid) nvalid++;
            if (k == skip) exp_sync = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        t     = 8'h0;
        @(negedge clk);
        chk("idle busy", {31'h0, busy}, 32'h0);
        chk("idle w_valid", {31'h0, w_valid}, 32'h0);
        chk("idle sync_err", {31'h0, sync_err}, {31'h0, exp_sync});
        chk("w_valid count", nvalid, 32'd80);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] ones;
        logic [31:0]  got;

        abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        ones = {16{32'hFFFFFFFF}};

        tbl[0] = '{1'b0,  0, 32'h61626380};
        tbl[1] = '{1'b0, 15, 32'h00000018};
        tbl[2] = '{1'b0, 16, 32'hC2C4C700};
        tbl[3] = '{1'b0, 17, 32'h00000000};
        tbl[4] = '{1'b0, 18, 32'h00000030};
        tbl[5] = '{1'b1,  0, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 16, 32'h00000000};
        tbl[7] = '{1'b1, 17, 32'h00000000};
        tbl[8] = '{1'b1, 18, 32'h00000000};
        tbl[9] = '{1'b1, 19, 32'hFFFFFFFF};

        // Reset held with random inputs, then released with valid low
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            valid = 1'($urandom_range(0, 1));
            block = randblk();
            @(negedge clk);
            chk("reset w_t", w_t, 32'h0);
            chk("reset w_valid", {31'h0, w_valid}, 32'h0);
            chk("reset busy", {31'h0, busy}, 32'h0);
            chk("reset sync_err", {31'h0, sync_err}, 32'h0);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post-reset w_t", w_t, 32'h0);
            chk("post-reset busy", {31'h0, busy}, 32'h0);
            chk("post-reset w_valid", {31'h0, w_valid}, 32'h0);
        end

        // Known-answer blocks, back to back, then the vector table
        run_block(abc, -1, -1, 1'b0);
        obs_abc = obs;
        run_block(ones, -1, -1, 1'b0);
        obs_ones = obs;
        for (int i = 0; i < 10; i++) begin
            got = tbl[i].use_ones ? obs_ones[tbl[i].k] : obs_abc[tbl[i].k];
            chk($sformatf("table[%0d] W%0d", i, tbl[i].k), got, tbl[i].exp);
        end

        // Back-to-back random blocks, first with a mid-run valid pulse
        run_block(randblk(), -1, -1, 1'b1);
        run_block(randblk(), -1, -1, 1'b0);

        // Round index skip at 40: sticky error, cleared by next accepted block
        run_block(randblk(), 40, -1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sync_err sticky idle", {31'h0, sync_err}, 32'h1);
        run_block(randblk(), -1, -1, 1'b0);

        // Reset asserted at round 37, then a clean block
        run_block(randblk(), -1, 37, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after rst busy", {31'h0, busy}, 32'h0);
        run_block(randblk(), -1, -1, 1'b0);

        // More random blocks against the model
        repeat (3) run_block(randblk(), -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
